fifo_rd_stream: RTL and testbench

Read-side adapter for fifo_sync. Converts fifo_sync's rd_en / rd_data / empty interface, which has a fixed read latency set by DO_REG, into a valid/ready stream. It uses credit-based prefetch plus a small holding buffer to sustain one beat per cycle under backpressure without losing or reordering data. It sits between a fifo_sync instance and any downstream consumer, for example a UART TX or a packetiser.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_rd_stream_buf.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 99 +++++++++
 tb/tb_fifo_rd_stream.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers shared by fifo_sync and its stream adapters.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int rd_latency(input int do_reg);
        return 1 + do_reg;
    endfunction

    // One entry beyond the read latency keeps a full-rate stream alive across a single stall.
    function automatic int buf_depth(input int do_reg);
        return rd_latency(do_reg) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: small circular holding buffer; the head word is presented
// from registered storage and count tracks occupancy.
module fifo_rd_stream_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int DEPTH = 3,
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head_data
);
    localparam int               PTR_W    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: the storage array is reset so the head word, and therefore m_data, reads zero out of reset.
    // NOTE: non-blocking assignments make every register here update from pre-edge values, order-independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ptr_next(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_next(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem[r_head];

    // Credit logic upstream guarantees a free slot for every landing word.
    overflow_chk : assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns fifo_sync's fixed-latency rd_en/rd_data port into a valid/ready stream.
// Define FIFO_RD_STREAM_STATS_EN to add the stat_beats / stat_stalls counters.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 72,
    parameter int DO_REG     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_ready,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stalls
`endif
);
    localparam int RD_LAT    = rd_latency(DO_REG);
    localparam int BUF_DEPTH = buf_depth(DO_REG);
    localparam int CNT_W     = clog2(BUF_DEPTH + 1);

    logic [RD_LAT-1:0] r_inflight_sr;
    logic [CNT_W-1:0]  w_inflight;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit_used;
    logic              w_push;
    logic              w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight_sr <= '0;
        end else begin
            r_inflight_sr[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_inflight_sr[i] <= r_inflight_sr[i-1];
            end
        end
    end

    // NOTE: w_inflight gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_inflight_sr[i]);
        end
    end

    assign w_push  = r_inflight_sr[RD_LAT-1];
    assign w_pop   = m_valid & m_ready;
    assign m_valid = (w_count != '0);

    // Words buffered or still in the read pipe hold a slot; a same-cycle pop frees one.
    assign w_credit_used = {1'b0, w_count} + {1'b0, w_inflight} - {{CNT_W{1'b0}}, w_pop};
    assign fifo_rd_en    = ~rst & fifo_ready & ~fifo_empty
                         & (w_credit_used < (CNT_W + 1)'(BUF_DEPTH));

    fifo_rd_stream_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_data (m_data)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_beats  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_pop) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (m_valid && !m_ready) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a fifo_sync stand-in, an in-order scoreboard
// and a per-cycle compare process for the stream rules.
module tb_fifo_rd_stream;
    localparam int W         = 72;
    localparam int BUF_DEPTH = 3;
    localparam int EXP_LAT   = 3;

    logic         clk          = 1'b0;
    logic         rst          = 1'b1;
    logic         fifo_ready   = 1'b0;
    logic         fifo_empty   = 1'b1;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_rd_data = '0;
    logic         m_valid;
    logic         m_ready      = 1'b0;
    logic [W-1:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]  stat_beats;
    logic [31:0]  stat_stalls;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .FIFO_WIDTH (W),
        .DO_REG     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_ready   (fifo_ready),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_stalls  (stat_stalls)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // fifo_sync stand-in: two-cycle read latency, bulk write port driven by the stimulus.
    logic [W-1:0] fq[$];
    logic [W-1:0] pipe0 = '0;
    logic [W-1:0] wr_buf [16];
    int           wr_n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            pipe0        <= '0;
            fifo_rd_data <= '0;
            fifo_empty   <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                pipe0 <= fq.pop_front();
            end
            fifo_rd_data <= pipe0;
            for (int i = 0; i < wr_n; i++) begin
                fq.push_back(wr_buf[i]);
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard: words written since the last reset must come out in order.
    logic [W-1:0] exp_mem [1024];
    int           wr_idx     = 0;
    int           rd_idx     = 0;
    int           issued     = 0;
    int           accepted   = 0;
    int           outstanding;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            rd_idx     = wr_idx;
            issued     = 0;
            accepted   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", m_valid, 1'b1);
                check("stall_hold_data", m_data, prev_data);
            end
            if (fifo_rd_en) begin
                check("rd_en_while_empty", fifo_empty, 1'b0);
            end
            outstanding = issued + int'(fifo_rd_en) - accepted - int'(m_valid & m_ready);
            if (fifo_rd_en || m_valid) begin
                check("credit_bound", outstanding <= BUF_DEPTH, 1'b1);
            end
            if (m_valid && m_ready) begin
                if (rd_idx == wr_idx) begin
                    check("beat_unexpected", m_valid, 1'b0);
                end else begin
                    check("beat_data", m_data, exp_mem[rd_idx % 1024]);
                    rd_idx++;
                end
                accepted++;
            end
            if (fifo_rd_en) begin
                issued++;
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        logic [95:0] r;
        for (int i = 0; i < n; i++) begin
            r         = {$urandom, $urandom, $urandom};
            wr_buf[i] = r[W-1:0];
        end
    endtask

    // Leaves the caller just after the edge that lands the words, so reads can start this cycle.
    task automatic write_burst(input int n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            exp_mem[wr_idx % 1024] = wr_buf[i];
            wr_idx++;
        end
        wr_n = n;
        @(posedge clk);
        #1;
        wr_n = 0;
    endtask

    task automatic wait_accepted(input string name, input int target, input int budget);
        int c;
        c = 0;
        while (accepted < target && c < budget) begin
            tick();
            c++;
        end
        check(name, accepted, target);
    endtask

    task automatic single_word(input string tag, input logic [W-1:0] w);
        int lat;
        int iss0;
        iss0      = issued;
        wr_buf[0] = w;
        write_burst(1);
        tick();
        check({tag, "_rd_en"}, fifo_rd_en, 1'b1);
        lat = 0;
        while (!m_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, EXP_LAT);
        check({tag, "_data"}, m_data, w);
        tick();
        check({tag, "_valid_drop"}, m_valid, 1'b0);
        check({tag, "_reads"}, issued - iss0, 1);
    endtask

    initial begin
        int c;
        int n;
        int nz;
        int iss0;
        int acc0;

        repeat (2) @(posedge clk);
        tick();
        check("reset_rd_en", fifo_rd_en, 1'b0);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_m_data", m_data, '0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        fifo_ready = 1'b1;
        m_ready    = 1'b1;
        repeat (2) tick();

        single_word("single", 72'h0123456789ABCDEF01);

        fill_random(16);
        acc0 = accepted;
        write_burst(16);
        c = 0;
        while (!m_valid && c < 10) begin
            tick();
            c++;
        end
        check("burst_start", m_valid, 1'b1);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n += int'(m_valid);
            tick();
        end
        check("burst_gapless", n, 16);
        check("burst_end", m_valid, 1'b0);
        check("burst_count", accepted - acc0, 16);

        @(posedge clk);
        #1;
        m_ready = 1'b0;
        fill_random(16);
        iss0 = issued;
        acc0 = accepted;
        write_burst(16);
        repeat (20) tick();
        check("bp_reads", issued - iss0, BUF_DEPTH);
        check("bp_valid", m_valid, 1'b1);
        c = 0;
        while (accepted - acc0 < 16 && c < 200) begin
            @(posedge clk);
            #1;
            m_ready = ~m_ready;
            tick();
            c++;
        end
        check("bp_delivered", accepted - acc0, 16);
        check("bp_total_reads", issued - iss0, 16);
        @(posedge clk);
        #1;
        m_ready = 1'b1;

        nz = 0;
        repeat (10) begin
            tick();
            nz += int'(fifo_rd_en | m_valid);
        end
        check("idle_quiet", nz, 0);
        single_word("refill", 72'hFEDCBA9876543210AA);

        fill_random(8);
        iss0 = issued;
        acc0 = accepted;
        write_burst(8);
        tick();
        tick();
        @(posedge clk);
        #1;
        fifo_ready = 1'b0;
        repeat (10) tick();
        check("frdy_reads", issued - iss0, 2);
        check("frdy_drained", accepted - acc0, 2);
        check("frdy_idle_valid", m_valid, 1'b0);
        fifo_ready = 1'b1;
        wait_accepted("frdy_resume", acc0 + 8, 50);

        fill_random(16);
        write_burst(16);
        repeat (5) tick();
        check("pre_rst_valid", m_valid, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", m_valid, 1'b0);
        check("rst_async_rd_en", fifo_rd_en, 1'b0);
        check("rst_async_data", m_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nz = 0;
        repeat (10) begin
            tick();
            nz += int'(fifo_rd_en | m_valid);
        end
        check("post_rst_quiet", nz, 0);
        single_word("post_rst", 72'h5A5A5A5A5AC3C3C3C3);

`ifdef FIFO_RD_STREAM_STATS_EN
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("stats_rst_beats", stat_beats, '0);
        check("stats_rst_stalls", stat_stalls, '0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b0;
        tick();
        acc0 = accepted;
        fill_random(8);
        write_burst(8);
        c = 0;
        while (!m_valid && c < 10) begin
            tick();
            c++;
        end
        check("stats_first_valid", m_valid, 1'b1);
        repeat (4) tick();
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_accepted("stats_delivered", acc0 + 8, 50);
        tick();
        check("stats_beats", stat_beats, 8);
        check("stats_stalls", stat_stalls, 5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("stats_clr_beats", stat_beats, '0);
        check("stats_clr_stalls", stat_stalls, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

endmodule
